// File: rtl/mult_fu.sv
`default_nettype none
// ============================================================================
//  Module   : mult_fu
//  Purpose  : Pipelined integer multiply functional unit (MUL, MULH, MULHSU,
//             MULHU). Accepts one issued instruction per cycle, forms the
//             64-bit product over STAGES register stages (one multiplier
//             chunk per stage, LSB first) and hands the tagged result to the
//             CDB arbiter through a valid/ack handshake.
//  Ports    : clock, reset          - clock, async active-high reset
//             in_valid/in_ready     - issue handshake (in_ready is the RS
//                                     fu-ready bit, combinational from ack)
//             in_func               - 0=MUL 1=MULH 2=MULHSU 3=MULHU
//             in_rs1/in_rs2         - operand values
//             in_dest_pr            - destination physical register tag
//             squash                - kill every in-flight instruction
//             out_valid/out_ack     - result handshake
//             out_result/out_dest_pr- result value and tag (registered)
//             perf_issued/perf_stall- present only with MULT_PERF_EN
//  Options  : MULT_PERF_EN - adds accept and output-stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_fu #(
  parameter int XLEN   = 32,
  parameter int PRW    = 6,
  parameter int STAGES = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_func,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [PRW-1:0]  in_dest_pr,
  input  logic            squash,
  output logic            out_valid,
  input  logic            out_ack,
  output logic [XLEN-1:0] out_result,
  output logic [PRW-1:0]  out_dest_pr
`ifdef MULT_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  localparam int PW    = 2 * XLEN;       // full product width
  localparam int CHUNK = PW / STAGES;    // multiplier bits retired per stage

  localparam logic [1:0] FUNC_MUL    = 2'd0;
  localparam logic [1:0] FUNC_MULH   = 2'd1;
  localparam logic [1:0] FUNC_MULHSU = 2'd2;

  // Per-stage pipeline registers
  logic            valid_q  [STAGES];
  logic            valid_d  [STAGES];
  logic [1:0]      func_q   [STAGES];
  logic [1:0]      func_d   [STAGES];
  logic [PRW-1:0]  dest_q   [STAGES];
  logic [PRW-1:0]  dest_d   [STAGES];
  logic [PW-1:0]   mcand_q  [STAGES];
  logic [PW-1:0]   mcand_d  [STAGES];
  logic [PW-1:0]   mplier_q [STAGES];
  logic [PW-1:0]   mplier_d [STAGES];
  logic [PW-1:0]   acc_q    [STAGES];
  logic [PW-1:0]   acc_d    [STAGES];

  logic            advance;
  logic            accept;
  logic [PW-1:0]   rs1_ext;
  logic [PW-1:0]   rs2_ext;

  // Partial product of the multiplicand and the low CHUNK bits of the
  // remaining multiplier; only the low PW bits are kept (wrap-around is
  // what makes the signed forms come out right).
  function automatic logic [PW-1:0] chunk_pp(input logic [PW-1:0] mcand,
                                             input logic [PW-1:0] mplier);
    logic [PW-1:0] digit;
    digit = (mplier << (PW - CHUNK)) >> (PW - CHUNK);
    return mcand * digit;
  endfunction

  // Whole pipe moves together; it only freezes when a result sits unacked.
  assign advance  = ~out_valid | out_ack;
  assign in_ready = advance;
  assign accept   = in_valid & advance & ~squash;

  assign rs1_ext = ((in_func == FUNC_MULH) || (in_func == FUNC_MULHSU))
                 ? {{(PW-XLEN){in_rs1[XLEN-1]}}, in_rs1}
                 : {{(PW-XLEN){1'b0}}, in_rs1};
  assign rs2_ext = (in_func == FUNC_MULH)
                 ? {{(PW-XLEN){in_rs2[XLEN-1]}}, in_rs2}
                 : {{(PW-XLEN){1'b0}}, in_rs2};

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k]  = valid_q[k];
      func_d[k]   = func_q[k];
      dest_d[k]   = dest_q[k];
      mcand_d[k]  = mcand_q[k];
      mplier_d[k] = mplier_q[k];
      acc_d[k]    = acc_q[k];
    end

    if (advance) begin
      valid_d[0]  = accept;
      func_d[0]   = in_func;
      dest_d[0]   = in_dest_pr;
      mcand_d[0]  = rs1_ext;
      mplier_d[0] = rs2_ext >> CHUNK;
      acc_d[0]    = chunk_pp(rs1_ext, rs2_ext);
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k]  = valid_q[k-1];
        func_d[k]   = func_q[k-1];
        dest_d[k]   = dest_q[k-1];
        mcand_d[k]  = mcand_q[k-1];
        mplier_d[k] = mplier_q[k-1] >> CHUNK;
        acc_d[k]    = acc_q[k-1]
                    + (chunk_pp(mcand_q[k-1], mplier_q[k-1]) << (k * CHUNK));
      end
    end

    // Squash overrides both the shift and the accept; data may stay stale.
    if (squash) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k]  <= 1'b0;
        func_q[k]   <= 2'd0;
        dest_q[k]   <= '0;
        mcand_q[k]  <= '0;
        mplier_q[k] <= '0;
        acc_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k]  <= valid_d[k];
        func_q[k]   <= func_d[k];
        dest_q[k]   <= dest_d[k];
        mcand_q[k]  <= mcand_d[k];
        mplier_q[k] <= mplier_d[k];
        acc_q[k]    <= acc_d[k];
      end
    end
  end

  // Outputs are pure functions of the last stage register.
  assign out_valid   = valid_q[STAGES-1];
  assign out_dest_pr = dest_q[STAGES-1];
  assign out_result  = (func_q[STAGES-1] == FUNC_MUL)
                     ? acc_q[STAGES-1][XLEN-1:0]
                     : acc_q[STAGES-1][PW-1:XLEN];

`ifdef MULT_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issued_q <= 32'd0;
      perf_stall_q  <= 32'd0;
    end else begin
      if (accept) begin
        perf_issued_q <= perf_issued_q + 32'd1;
      end
      if (out_valid & ~out_ack) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_fu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_fu
//  Purpose  : Self-checking bench for mult_fu. Expected results are pushed
//             to a scoreboard queue at accept and popped when the unit hands
//             a result over.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_fu;

  localparam int STAGES = 4;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_func;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [5:0]  in_dest_pr;
  logic        squash;
  logic        out_valid;
  logic        out_ack;
  logic [31:0] out_result;
  logic [5:0]  out_dest_pr;
`ifdef MULT_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  int errors = 0;
  int checks = 0;
  int n_accept = 0;
  int n_stall = 0;
  logic [37:0] sb[$];

  mult_fu #(.XLEN(32), .PRW(6), .STAGES(STAGES)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_func    (in_func),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_dest_pr (in_dest_pr),
    .squash     (squash),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .out_result (out_result),
    .out_dest_pr(out_dest_pr)
`ifdef MULT_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_stall (perf_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference multiply from 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sbv, ua, ub;
    logic [63:0] p;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (f)
      2'd0:    begin p = ua * ub; return p[31:0]; end
      2'd1:    p = sa * sbv;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return p[63:32];
  endfunction

  // Drive one cycle: apply inputs, sample outputs before the edge, update
  // the scoreboard on accept/squash, then step past the next rising edge.
  task automatic drive_cycle(input logic v, input logic [1:0] f,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [5:0] tag, input logic ack, input logic sq,
                             output logic ov, output logic [31:0] ores,
                             output logic [5:0] otag, output logic ordy);
    in_valid = v; in_func = f; in_rs1 = a; in_rs2 = b; in_dest_pr = tag;
    out_ack = ack; squash = sq;
    #1;
    ov = out_valid; ores = out_result; otag = out_dest_pr; ordy = in_ready;
    if (ov && !ack) n_stall++;
    if (sq) sb.delete();
    else if (v && ordy) begin
      sb.push_back({tag, model(f, a, b)});
      n_accept++;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 0; in_func = 0; in_rs1 = 0; in_rs2 = 0;
    in_dest_pr = 0; squash = 0; out_ack = 0;
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h required 0", out_result); end
    checks++; if (out_dest_pr !== 6'd0) begin errors++; $display("FAIL reset_dest: got %0d required 0", out_dest_pr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_mul;
    logic ov, rdy; logic [31:0] res; logic [5:0] tg; logic [37:0] exp; int lat;
    lat = -1;
    drive_cycle(1'b1, 2'd0, 32'h7, 32'hFFFF_FFFD, 6'd5, 1'b1, 1'b0, ov, res, tg, rdy);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      drive_cycle(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 1'b1, 1'b0, ov, res, tg, rdy);
      if (ov) begin lat = cyc; break; end
    end
    checks++; if (lat != STAGES) begin errors++; $display("FAIL mul_latency: got %0d required %0d", lat, STAGES); end
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h required ffffffeb", res); end
    checks++; if (tg !== 6'd5) begin errors++; $display("FAIL mul_dest: got %0d required 5", tg); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL mul_sb: got output, required none"); end
    else begin
      exp = sb.pop_front();
      if ({tg, res} !== exp) begin errors++; $display("FAIL mul_sb: got %h required %h", {tg, res}, exp); end
    end
  endtask

  task automatic test_mulh_variants;
    logic ov, rdy; logic [31:0] res; logic [5:0] tg; logic [37:0] exp; int got;
    logic [31:0] lit [3];
    lit[0] = 32'h0000_0000; lit[1] = 32'h8000_0000; lit[2] = 32'h7FFF_FFFF;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      drive_cycle(cyc < 3, 2'(cyc + 1), 32'h8000_0000, 32'hFFFF_FFFF, 6'(cyc + 1),
                  1'b1, 1'b0, ov, res, tg, rdy);
      if (ov) begin
        checks++;
        if (res !== lit[got]) begin errors++; $display("FAIL mulh_lit%0d: got %h required %h", got, res, lit[got]); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL mulh_sb: got unexpected output %h", res); end
        else begin
          exp = sb.pop_front();
          if ({tg, res} !== exp) begin errors++; $display("FAIL mulh_sb: got %h required %h", {tg, res}, exp); end
        end
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL mulh_count: got %0d required 3", got); end
  endtask

  task automatic test_back_to_back;
    logic ov, rdy; logic [31:0] res; logic [5:0] tg; logic [37:0] exp;
    for (int cyc = 0; cyc < STAGES + 8; cyc++) begin
      drive_cycle(cyc < 8, 2'($urandom_range(0, 3)), $urandom, $urandom, 6'(20 + cyc),
                  1'b1, 1'b0, ov, res, tg, rdy);
      if (cyc < 8) begin
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready: cyc %0d got %b required 1", cyc, rdy); end
      end
      if (cyc >= STAGES) begin
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL b2b_valid: cyc %0d got %b required 1", cyc, ov); end
      end
      if (ov) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_sb: got unexpected output %h", res); end
        else begin
          exp = sb.pop_front();
          if ({tg, res} !== exp) begin errors++; $display("FAIL b2b_sb: got %h required %h", {tg, res}, exp); end
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_left: got %0d pending required 0", sb.size()); end
  endtask

  task automatic test_stall;
    logic ov, rdy, ack, held; logic [31:0] res, hres; logic [5:0] tg, htag;
    logic [37:0] exp; int issued, got;
    issued = 0; got = 0; held = 1'b0; hres = 0; htag = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      ack = !(cyc >= 6 && cyc < 9);
      drive_cycle(issued < 10, 2'(issued), 32'h100 + 32'(issued), 32'(issued * 3 + 1),
                  6'(40 + issued), ack, 1'b0, ov, res, tg, rdy);
      if (issued < 10 && rdy) issued++;
      if (ov && !ack) begin
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b required 0", rdy); end
        if (held) begin
          checks++;
          if ({tg, res} !== {htag, hres}) begin errors++; $display("FAIL stall_hold: got %h required %h", {tg, res}, {htag, hres}); end
        end
        held = 1'b1; hres = res; htag = tg;
      end
      if (ov && ack) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stall_sb: got unexpected output %h", res); end
        else begin
          exp = sb.pop_front();
          if ({tg, res} !== exp) begin errors++; $display("FAIL stall_sb: got %h required %h", {tg, res}, exp); end
        end
        got++;
      end
    end
    checks++; if (!held) begin errors++; $display("FAIL stall_seen: got no stall cycle, required 3"); end
    checks++;
    if (got != 10 || sb.size() != 0) begin errors++; $display("FAIL stall_count: got %0d results %0d pending required 10 and 0", got, sb.size()); end
  endtask

  task automatic test_squash;
    logic ov, rdy; logic [31:0] res; logic [5:0] tg; logic [37:0] exp; int got;
    for (int cyc = 0; cyc < 3; cyc++)
      drive_cycle(1'b1, 2'd0, 32'(cyc + 2), 32'd9, 6'(50 + cyc), 1'b1, 1'b0, ov, res, tg, rdy);
    drive_cycle(1'b1, 2'd0, 32'd5, 32'd5, 6'd53, 1'b1, 1'b1, ov, res, tg, rdy);
    for (int cyc = 0; cyc < STAGES; cyc++) begin
      drive_cycle(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 1'b1, 1'b0, ov, res, tg, rdy);
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL squash_valid: cyc %0d got %b required 0", cyc, ov); end
    end
    got = 0;
    drive_cycle(1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd60, 1'b1, 1'b0, ov, res, tg, rdy);
    for (int cyc = 0; cyc < 20 && got < 1; cyc++) begin
      drive_cycle(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 1'b1, 1'b0, ov, res, tg, rdy);
      if (ov) begin
        checks++;
        if ({tg, res} !== {6'd60, 32'hFFFF_FFFE}) begin errors++; $display("FAIL squash_after: got %h required %h", {tg, res}, {6'd60, 32'hFFFF_FFFE}); end
        if (sb.size() != 0) exp = sb.pop_front();
        got++;
      end
    end
    checks++; if (got != 1 || sb.size() != 0) begin errors++; $display("FAIL squash_count: got %0d results %0d pending required 1 and 0", got, sb.size()); end
  endtask

  task automatic test_reset_mid;
    logic ov, rdy; logic [31:0] res; logic [5:0] tg;
    ov = 1'b0;
    drive_cycle(1'b1, 2'd0, 32'h7, 32'hFFFF_FFFD, 6'd33, 1'b0, 1'b0, ov, res, tg, rdy);
    drive_cycle(1'b1, 2'd0, 32'h3, 32'h3, 6'd34, 1'b0, 1'b0, ov, res, tg, rdy);
    for (int cyc = 0; cyc < 20 && !ov; cyc++)
      drive_cycle(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b0, ov, res, tg, rdy);
    checks++; if (out_valid !== 1'b1 || out_dest_pr !== 6'd33) begin errors++; $display("FAIL rmid_pre: got valid %b dest %0d required 1 and 33", out_valid, out_dest_pr); end
`ifdef MULT_PERF_EN
    checks++; if (perf_issued !== 32'(n_accept)) begin errors++; $display("FAIL perf_issued: got %0d required %0d", perf_issued, n_accept); end
    checks++; if (perf_stall !== 32'(n_stall)) begin errors++; $display("FAIL perf_stall: got %0d required %0d", perf_stall, n_stall); end
`endif
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b required 0", out_valid); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL rmid_result: got %h required 0", out_result); end
    checks++; if (out_dest_pr !== 6'd0) begin errors++; $display("FAIL rmid_dest: got %0d required 0", out_dest_pr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b required 1", in_ready); end
`ifdef MULT_PERF_EN
    checks++; if (perf_issued !== 32'd0 || perf_stall !== 32'd0) begin errors++; $display("FAIL rmid_perf: got %0d/%0d required 0/0", perf_issued, perf_stall); end
`endif
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
    for (int cyc = 0; cyc < STAGES + 1; cyc++)
      drive_cycle(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 1'b1, 1'b0, ov, res, tg, rdy);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rmid_after: got valid %b required 0", ov); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh_variants();
    test_back_to_back();
    test_stall();
    test_squash();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
